// File: rtl/i2c_reg_master.sv
// rtl/i2c_reg_master.sv - I2C master performing single-byte register reads and writes
//
// Purpose: accepts one register command at a time and runs the bus sequence
//   write: START, {addr,0}, ACK, reg, ACK, data, ACK, STOP
//   read : START, {addr,1}, ACK, reg, ACK, 8 data bits in, master NACK, STOP
// then reports completion with a one-cycle rsp_valid pulse.
//
// Parameters:
//   CLK_DIV        clk cycles per SCL quarter-period (2..255)
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   cmd_valid      command request; accepted when cmd_ready is also high
//   cmd_ready      idle and able to accept a command
//   cmd_rw         1 = register read, 0 = register write
//   cmd_slave_addr 7-bit device address
//   cmd_reg_addr   8-bit register address
//   cmd_wdata      write data
//   rsp_valid      one-cycle completion pulse
//   rsp_rdata      read data (0x00 for writes)
//   rsp_nack       some slave ACK slot was sampled high
//   scl_o          SCL level (push-pull)
//   sda_oe         1 drives SDA low, 0 releases it
//   sda_i          sampled SDA line
// Build option:
//   I2C_REG_MASTER_NACK_ABORT_EN  when defined, a NACK in the slave-address or
//   register-address ACK slot ends the transfer early through STOP.
module i2c_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_slave_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [3:0] {
    IDLE, START, SADDR, SADDR_ACK, RADDR, RADDR_ACK,
    WDATA, WDATA_ACK, RDATA, MNACK, STOP, DONE
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [1:0]  q;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        rw;
  logic [7:0]  reg_addr;
  logic [7:0]  wdata;
  logic        nack;
  logic        tick;
  logic        scl_nxt;
  logic        oe_nxt;

  assign tick = (div_cnt == 8'(CLK_DIV - 1));

  // Bus levels for the current state and quarter. They are registered, so the
  // pins follow the FSM one clk later; every transition shifts by the same cycle.
  always_comb begin
    scl_nxt = 1'b1;
    oe_nxt  = 1'b0;
    case (state)
      START: oe_nxt = q[1];
      SADDR, RADDR, WDATA: begin
        scl_nxt = q[1];
        oe_nxt  = ~shreg[7];
      end
      SADDR_ACK, RADDR_ACK, WDATA_ACK, RDATA, MNACK: scl_nxt = q[1];
      STOP: begin
        // q0: SCL low/SDA low, q1: SCL high/SDA low, q2-q3: SDA released
        scl_nxt = (q != 2'd0);
        oe_nxt  = ~q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      q         <= 2'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      rw        <= 1'b0;
      reg_addr  <= 8'd0;
      wdata     <= 8'd0;
      nack      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_nack  <= 1'b0;
      scl_o     <= 1'b1;
      sda_oe    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      scl_o     <= scl_nxt;
      sda_oe    <= oe_nxt;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          div_cnt   <= 8'd0;
          q         <= 2'd0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            state     <= START;
            shreg     <= {cmd_slave_addr, cmd_rw};
            rw        <= cmd_rw;
            reg_addr  <= cmd_reg_addr;
            wdata     <= cmd_wdata;
            nack      <= 1'b0;
            bit_cnt   <= 3'd7;
          end
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_nack  <= nack;
          rsp_rdata <= rw ? shreg : 8'h00;
        end
        default: begin
          if (!tick) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            q       <= q + 2'd1;
            // q2->q3 boundary: SCL has been high for a full quarter, sample SDA
            if (q == 2'd2) begin
              case (state)
                SADDR_ACK, RADDR_ACK: begin
                  nack <= nack | sda_i;
`ifdef I2C_REG_MASTER_NACK_ABORT_EN
                  // Early exit: STOP is entered at its last quarter (SCL high,
                  // SDA released), so the bus is idle at the ACK slot boundary.
                  if (sda_i) state <= STOP;
`endif
                end
                WDATA_ACK: nack  <= nack | sda_i;
                RDATA:     shreg <= {shreg[6:0], sda_i};
                default: ;
              endcase
            end
            if (q == 2'd3) begin
              case (state)
                START: state <= SADDR;
                SADDR: begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) state <= SADDR_ACK;
                end
                SADDR_ACK: begin
                  shreg <= reg_addr;
                  state <= RADDR;
                end
                RADDR: begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) state <= RADDR_ACK;
                end
                RADDR_ACK: begin
                  if (rw) begin
                    state <= RDATA;
                  end else begin
                    shreg <= wdata;
                    state <= WDATA;
                  end
                end
                WDATA: begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) state <= WDATA_ACK;
                end
                WDATA_ACK: state <= STOP;
                RDATA: begin
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) state <= MNACK;
                end
                MNACK: state <= STOP;
                STOP:  state <= DONE;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb/tb_i2c_reg_master.sv - scoreboard bench for i2c_reg_master with an I2C slave model
module tb_i2c_reg_master;

  localparam int CLK_DIV   = 4;
  localparam int LAT_FULL  = 116 * CLK_DIV + 1;
  localparam int LAT_ABORT = 40 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_slave_addr = 7'd0;
  logic [7:0] cmd_reg_addr = 8'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       scl_o;
  logic       sda_oe;
  logic       sda_i;
  logic       slv_pull = 1'b0;

  assign sda_i = ~(sda_oe | slv_pull);

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_slave_addr(cmd_slave_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] rdata; logic nack; int lat; time t_acc; } rsp_exp_t;
  typedef struct { logic ack0; logic ack1; logic ack2; logic [7:0] rd; } slv_cfg_t;

  rsp_exp_t   rsp_q[$];
  logic [7:0] byte_q[$];
  slv_cfg_t   cfg_q[$];
  int total = 0;
  int bad   = 0;

  // slave model / monitor state
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_xfer = 1'b0;
  logic       is_read = 1'b0;
  logic       ready_chk = 1'b0;
  logic [7:0] rx = 8'd0;
  int         bitn = 0;
  int         byte_idx = 0;
  slv_cfg_t   cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [6:0] sa, input logic [7:0] ra,
                       input logic [7:0] wd, input logic a0, input logic a1, input logic a2,
                       input logic [7:0] rd, input bit want_rsp, input logic [7:0] exp_rdata,
                       input logic exp_nack, input int exp_lat);
    int n;
    rsp_exp_t e;
    slv_cfg_t c;
    c.ack0 = a0; c.ack1 = a1; c.ack2 = a2; c.rd = rd;
    cfg_q.push_back(c);
    cmd_rw = rw; cmd_slave_addr = sa; cmd_reg_addr = ra; cmd_wdata = wd;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: cmd_ready still %0b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.t_acc = $time; e.rdata = exp_rdata; e.nack = exp_nack; e.lat = exp_lat;
    if (want_rsp) rsp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    fork
      // monitor: response scoreboard and protocol-level slave
      forever begin
        logic scl, sda;
        logic [7:0] eb;
        rsp_exp_t e;
        @(negedge clk);
        if (rst) begin
          prev_scl = 1'b1; prev_sda = 1'b1; in_xfer = 1'b0; slv_pull = 1'b0; ready_chk = 1'b0;
        end else begin
          if (ready_chk) begin
            check("ready_after_rsp", cmd_ready, 1);
            ready_chk = 1'b0;
          end
          if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL rsp_unexpected: rsp_valid with rdata %0h, required no response", rsp_rdata);
            end else begin
              e = rsp_q.pop_front();
              check("rsp_rdata", rsp_rdata, e.rdata);
              check("rsp_nack", rsp_nack, e.nack);
              check("rsp_latency", int'((($time - 5) - e.t_acc) / 10), e.lat);
              check("ready_low_at_rsp", cmd_ready, 0);
              ready_chk = 1'b1;
            end
          end
          scl = scl_o;
          sda = sda_i;
          if (prev_scl && scl && prev_sda && !sda) begin
            if (cfg_q.size() == 0) begin
              total++; bad++;
              $display("FAIL start_unexpected: START seen, required none");
              cur.ack0 = 1'b1; cur.ack1 = 1'b1; cur.ack2 = 1'b1; cur.rd = 8'h00;
            end else begin
              cur = cfg_q.pop_front();
            end
            in_xfer = 1'b1; bitn = 0; byte_idx = 0; rx = 8'd0; is_read = 1'b0; slv_pull = 1'b0;
          end else if (prev_scl && scl && !prev_sda && sda) begin
            in_xfer = 1'b0; slv_pull = 1'b0;
          end else if (in_xfer && !prev_scl && scl) begin
            if (bitn < 8) begin
              rx = {rx[6:0], sda};
              bitn++;
              if (bitn == 8 && byte_idx < 3) begin
                if (byte_idx == 0) is_read = rx[0];
                if (byte_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL bus_byte: got %0h, required no byte", rx);
                end else begin
                  eb = byte_q.pop_front();
                  check("bus_byte", rx, eb);
                end
              end
            end else begin
              if (is_read && byte_idx == 2) check("master_nack", sda, 1);
              bitn = 0;
              byte_idx++;
            end
          end else if (in_xfer && prev_scl && !scl) begin
            if (bitn == 8) begin
              if (is_read && byte_idx == 2) slv_pull = 1'b0;
              else if (byte_idx == 0) slv_pull = cur.ack0;
              else if (byte_idx == 1) slv_pull = cur.ack1;
              else if (byte_idx == 2) slv_pull = cur.ack2;
              else slv_pull = 1'b0;
            end else if (is_read && byte_idx == 2) begin
              slv_pull = ~cur.rd[7 - bitn];
            end else begin
              slv_pull = 1'b0;
            end
          end
          prev_scl = scl;
          prev_sda = sda;
        end
      end
      // stimulus
      begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl", scl_o, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_nack", rsp_nack, 0);
        rst = 1'b0;
        @(negedge clk);

        // write 0x50/0x03 <- 0xA5, all ACKed
        byte_q.push_back(8'hA0); byte_q.push_back(8'h03); byte_q.push_back(8'hA5);
        issue(1'b0, 7'h50, 8'h03, 8'hA5, 1, 1, 1, 8'h00, 1, 8'h00, 0, LAT_FULL);

        // read 0x50/0x03 -> 0xA5
        byte_q.push_back(8'hA1); byte_q.push_back(8'h03); byte_q.push_back(8'hA5);
        issue(1'b1, 7'h50, 8'h03, 8'h00, 1, 1, 0, 8'hA5, 1, 8'hA5, 0, LAT_FULL);

        // address slot NACKed
`ifdef I2C_REG_MASTER_NACK_ABORT_EN
        byte_q.push_back(8'hA0);
        issue(1'b0, 7'h50, 8'h03, 8'hA5, 0, 1, 1, 8'h00, 1, 8'h00, 1, LAT_ABORT);
`else
        byte_q.push_back(8'hA0); byte_q.push_back(8'h03); byte_q.push_back(8'hA5);
        issue(1'b0, 7'h50, 8'h03, 8'hA5, 0, 1, 1, 8'h00, 1, 8'h00, 1, LAT_FULL);
`endif

        // read 0x2C/0xF0 -> 0x3C
        byte_q.push_back(8'h59); byte_q.push_back(8'hF0); byte_q.push_back(8'h3C);
        issue(1'b1, 7'h2C, 8'hF0, 8'h00, 1, 1, 0, 8'h3C, 1, 8'h3C, 0, LAT_FULL);

        // write with the data slot NACKed: never aborts
        byte_q.push_back(8'hFE); byte_q.push_back(8'h00); byte_q.push_back(8'h01);
        issue(1'b0, 7'h7F, 8'h00, 8'h01, 1, 1, 0, 8'h00, 1, 8'h00, 1, LAT_FULL);

        // reset at cycle 200 of a write: only the address byte reaches the bus
        byte_q.push_back(8'h22);
        issue(1'b0, 7'h11, 8'h22, 8'h33, 1, 1, 1, 8'h00, 0, 8'h00, 0, 0);
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_scl", scl_o, 1);
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // same write again completes normally
        byte_q.push_back(8'h22); byte_q.push_back(8'h22); byte_q.push_back(8'h33);
        issue(1'b0, 7'h11, 8'h22, 8'h33, 1, 1, 1, 8'h00, 1, 8'h00, 0, LAT_FULL);

        // write with a stray cmd_valid pulse while busy, then a back-to-back read
        byte_q.push_back(8'h1E); byte_q.push_back(8'h5A); byte_q.push_back(8'hC3);
        issue(1'b0, 7'h0F, 8'h5A, 8'hC3, 1, 1, 1, 8'h00, 1, 8'h00, 0, LAT_FULL);
        repeat (100) @(negedge clk);
        cmd_rw = 1'b1; cmd_slave_addr = 7'h55; cmd_reg_addr = 8'hFF; cmd_wdata = 8'h00;
        cmd_valid = 1'b1;
        check("busy_ready_low", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        byte_q.push_back(8'h67); byte_q.push_back(8'h44); byte_q.push_back(8'h96);
        issue(1'b1, 7'h33, 8'h44, 8'h00, 1, 1, 0, 8'h96, 1, 8'h96, 0, LAT_FULL);

        n = 0;
        while (rsp_q.size() != 0 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        repeat (20) @(negedge clk);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("byte_queue_drained", byte_q.size(), 0);
        check("cfg_queue_drained", cfg_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule

// File: doc/i2c_reg_master.md
I2C_REG_MASTER -- requirements
Module: i2c_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: block idle and able to accept a command.
REQ-006 SHALL have port cmd_rw, input, 1 bit: 1 = register read, 0 = register write.
REQ-007 SHALL have port cmd_slave_addr, input, 7 bits: target device address.
REQ-008 SHALL have port cmd_reg_addr, input, 8 bits: target register address.
REQ-009 SHALL have port cmd_wdata, input, 8 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 8 bits: read data, valid while rsp_valid is high.
REQ-012 SHALL have port rsp_nack, output, 1 bit: at least one slave ACK slot was sampled high.
REQ-013 SHALL have port scl_o, output, 1 bit: SCL level, driven push-pull.
REQ-014 SHALL have port sda_oe, output, 1 bit: 1 drives SDA low; 0 releases SDA.
REQ-015 SHALL have port sda_i, input, 1 bit: sampled SDA line.

Function
REQ-016 Handshake SHALL be: command accepted on a clk edge where cmd_valid and cmd_ready are both high; all cmd_* fields latched on that edge; cmd_ready low from the next cycle until the cycle after rsp_valid.
REQ-017 A quarter counter SHALL advance the FSM once every CLK_DIV clk cycles while busy; the counter SHALL be held at 0 in IDLE.
REQ-018 States SHALL be IDLE, START, SADDR, SADDR_ACK, RADDR, RADDR_ACK, WDATA, WDATA_ACK, RDATA, MNACK, STOP, DONE.
REQ-019 START (4 quarters) SHALL be: SCL high with SDA released for 2 quarters, then SDA driven low with SCL high for 2 quarters.
REQ-020 Each bit slot SHALL be 4 quarters: SCL low for q0-q1 with SDA changed only at the q0 boundary, then SCL high for q2-q3; sda_i SHALL be sampled at the q2->q3 boundary.
REQ-021 Bytes SHALL be shifted MSB first; SADDR byte SHALL be {cmd_slave_addr, cmd_rw}.
REQ-022 Write sequence SHALL be: START, SADDR, SADDR_ACK, RADDR, RADDR_ACK, WDATA, WDATA_ACK, STOP, DONE.
REQ-023 Read sequence SHALL be: START, SADDR, SADDR_ACK, RADDR, RADDR_ACK, RDATA (SDA released, 8 bits captured), MNACK (SDA released), STOP, DONE; no repeated START.
REQ-024 In ACK slots the master SHALL release SDA; a sampled 1 SHALL set the internal nack flag, which is cleared on command accept.
REQ-025 STOP (4 quarters) SHALL be: SDA low with SCL low in q0, SCL high in q1, SDA released in q2-q3.
REQ-026 DONE SHALL last one clk cycle, assert rsp_valid, present rsp_nack and rsp_rdata (0x00 for writes), then return to IDLE.
REQ-027 Without abort (REQ-033), latency from the accept edge to rsp_valid SHALL be exactly 116*CLK_DIV+1 clk cycles for both reads and writes.
REQ-028 cmd_valid asserted while busy SHALL be ignored and SHALL have no effect on the transfer in progress.
REQ-029 A bit counter SHALL count 7 down to 0 per byte; when it wraps to 7, the FSM SHALL move to the ACK state.

Reset
REQ-030 rst SHALL put the FSM in IDLE on the next clk edge, including mid-transfer, with no STOP generated.
REQ-031 Reset values SHALL be: scl_o=1, sda_oe=0, cmd_ready=1 (from the first cycle after rst deasserts), rsp_valid=0, rsp_rdata=0x00, rsp_nack=0; all counters SHALL be 0.

Configuration
REQ-032 Macro I2C_REG_MASTER_NACK_ABORT_EN SHALL select the NACK handling.
REQ-033 With I2C_REG_MASTER_NACK_ABORT_EN defined, a NACK sampled in SADDR_ACK or RADDR_ACK SHALL go directly to STOP, then DONE with rsp_nack=1 and rsp_rdata=0x00 (write abort after SADDR: 40*CLK_DIV+1 cycles).
REQ-034 With I2C_REG_MASTER_NACK_ABORT_EN undefined, a NACK SHALL only set rsp_nack and the full sequence SHALL complete.

Verification
REQ-035 Write slave 0x50, reg 0x03, data 0xA5 with the slave ACKing -> SDA bytes 0xA0, 0x03, 0xA5; rsp_nack=0; rsp_valid exactly 465 cycles after accept (CLK_DIV=4).
REQ-036 Read slave 0x50, reg 0x03 returning 0xA5 -> SDA bytes 0xA1, 0x03; master NACK; rsp_rdata=0xA5; rsp_nack=0.
REQ-037 Address slot NACKed with the abort macro defined -> STOP right after SADDR_ACK; rsp_valid at cycle 161; rsp_nack=1; rsp_rdata=0x00.
REQ-038 Same stimulus with the abort macro undefined -> full 465-cycle transfer; rsp_nack=1.
REQ-039 rst asserted at cycle 200 of a write -> next cycle scl_o=1, sda_oe=0, cmd_ready=1; a following command completes normally.
REQ-040 Second cmd_valid pulse during a transfer, plus back-to-back commands -> the pulse is ignored; cmd_ready returns one cycle after rsp_valid; the second command starts with START.
